// File: rtl/search_pkg.sv
// Shared widths, scheduler state and update-request type for the G0-G4 search pipeline.
// Group codes 5-7 travel through unchanged; table decode simply matches none of them.
package search_pkg;
    localparam int GROUP_NUM = 5;
    localparam int TUPLE_W   = 104;
    localparam int IDX_W     = 11;
    localparam int ENTRY_W   = 64;
    localparam int GRP_W     = 3;

    typedef enum logic [1:0] {SEARCH, DRAIN, WRITE} sched_state_t;

    typedef struct packed {
        logic [GRP_W-1:0]   group;
        logic [IDX_W-1:0]   index;
        logic [ENTRY_W-1:0] entry;
    } upd_req_t;
endpackage

// File: rtl/search_update_scheduler_if.sv
// Packet, update, launch and table-write signals of the search/update scheduler.
// The scheduler takes the slave side; the packet and update sources take the master side.
interface search_update_scheduler_if;
    import search_pkg::*;

    logic               pkt_valid;
    logic               pkt_ready;
    logic [TUPLE_W-1:0] pkt_tuple;
    logic               upd_valid;
    logic               upd_ready;
    logic [GRP_W-1:0]   upd_group;
    logic [IDX_W-1:0]   upd_index;
    logic [ENTRY_W-1:0] upd_entry;
    logic               srch_valid;
    logic [TUPLE_W-1:0] srch_tuple;
    logic               wr_en;
    logic [GRP_W-1:0]   wr_group;
    logic [IDX_W-1:0]   wr_index;
    logic [ENTRY_W-1:0] wr_entry;
    logic               draining;
    logic               pipe_empty;

    modport master (
        output pkt_valid, pkt_tuple, upd_valid, upd_group, upd_index, upd_entry,
        input  pkt_ready, upd_ready, srch_valid, srch_tuple, wr_en, wr_group,
        input  wr_index, wr_entry, draining, pipe_empty
    );

    modport slave (
        input  pkt_valid, pkt_tuple, upd_valid, upd_group, upd_index, upd_entry,
        output pkt_ready, upd_ready, srch_valid, srch_tuple, wr_en, wr_group,
        output wr_index, wr_entry, draining, pipe_empty
    );
endinterface

// File: rtl/sched_quiet_counter.sv
// Counts cycles since the last launch, saturating at PIPE_DEPTH; pipe_empty marks saturation.
// Latency: cleared on the edge after a launch cycle; no backpressure, free-running.
module sched_quiet_counter #(
    parameter int PIPE_DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic launch,
    output logic pipe_empty
);
    localparam int CNT_W = $clog2(PIPE_DEPTH + 1);
    localparam logic [CNT_W-1:0] QUIET_MAX = CNT_W'(PIPE_DEPTH);

    logic [CNT_W-1:0] quiet_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            quiet_cnt <= QUIET_MAX;
        end else if (launch) begin
            quiet_cnt <= '0;
        end else if (quiet_cnt != QUIET_MAX) begin
            quiet_cnt <= quiet_cnt + 1'b1;
        end
    end

    assign pipe_empty = (quiet_cnt == QUIET_MAX);
endmodule

// File: rtl/search_update_scheduler.sv
// Shares the G0-G4 tables between tuple launches and rule writes: SEARCH -> DRAIN -> WRITE.
// Launch/write are registered (1 cycle); a pending update stops admission after MAX_SEARCH_BURST tuples.
module search_update_scheduler
    import search_pkg::*;
#(
    parameter int PIPE_DEPTH       = 8,
    parameter int MAX_SEARCH_BURST = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    search_update_scheduler_if.slave bus
);
    localparam int BURST_W = $clog2(MAX_SEARCH_BURST + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_SEARCH_BURST);

    sched_state_t       state;
    logic [BURST_W-1:0] burst_cnt;
    upd_req_t           wr_req;
    logic               burst_full;
    logic               pkt_fire;
    logic               upd_fire;

    assign burst_full    = (burst_cnt == BURST_MAX);
    assign bus.pkt_ready = (state == SEARCH) && !(bus.upd_valid && burst_full);
    assign bus.upd_ready = (state == WRITE);
    assign pkt_fire      = bus.pkt_valid && bus.pkt_ready;
    assign upd_fire      = bus.upd_valid && bus.upd_ready;

    assign bus.wr_group = wr_req.group;
    assign bus.wr_index = wr_req.index;
    assign bus.wr_entry = wr_req.entry;

    sched_quiet_counter #(
        .PIPE_DEPTH (PIPE_DEPTH)
    ) u_quiet (
        .clk        (clk),
        .rst        (rst),
        .launch     (bus.srch_valid),
        .pipe_empty (bus.pipe_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= SEARCH;
            burst_cnt      <= '0;
            bus.srch_valid <= 1'b0;
            bus.srch_tuple <= '0;
            bus.wr_en      <= 1'b0;
            wr_req         <= '0;
            bus.draining   <= 1'b0;
        end else begin
            bus.srch_valid <= pkt_fire;
            if (pkt_fire) begin
                bus.srch_tuple <= bus.pkt_tuple;
            end

            // A write only follows a real handshake, so a withdrawn request leaves the tables alone.
            bus.wr_en <= upd_fire;
            if (upd_fire) begin
                wr_req <= '{group: bus.upd_group, index: bus.upd_index, entry: bus.upd_entry};
            end

            if (upd_fire || !bus.upd_valid) begin
                burst_cnt <= '0;
            end else if (pkt_fire && !burst_full) begin
                burst_cnt <= burst_cnt + 1'b1;
            end

            case (state)
                SEARCH: begin
                    if (bus.upd_valid && (burst_full || !bus.pkt_valid)) begin
                        state        <= DRAIN;
                        bus.draining <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.pipe_empty) begin
                        state        <= WRITE;
                        bus.draining <= 1'b0;
                    end
                end
                WRITE: begin
                    state <= SEARCH;
                end
                default: begin
                    state        <= SEARCH;
                    bus.draining <= 1'b0;
                end
            endcase
        end
    end
endmodule
